// File: rtl/apb_master_bridge.sv
// Single-channel APB4 requester bridging a transfer/SREADY request port onto an APB bus.
// Latency: accept in N -> SETUP N+1 -> ACCESS N+2; SDONE pulses N+3+k for k wait states.
// Backpressure: SREADY low while a transfer is in flight; requests offered when SREADY=0 are dropped.
//
// Ports:
//   PCLK, PRESET                     clock, synchronous active-high reset
//   transfer, SWRITE, SADDR, SWDATA,
//   SSTRB, SPROT, SREADY             request side (accept = transfer && SREADY)
//   SDONE, SERR, STIMEOUT, SRDATA    completion side (one-cycle pulse, read data held)
//   PSEL..PPROT, PREADY, PSLVERR,
//   PRDATA                           APB4 requester port
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int PROT_WIDTH = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  transfer,
    input  logic                  SWRITE,
    input  logic [ADDR_WIDTH-1:0] SADDR,
    input  logic [DATA_WIDTH-1:0] SWDATA,
    input  logic [STRB_WIDTH-1:0] SSTRB,
    input  logic [PROT_WIDTH-1:0] SPROT,
    output logic                  SREADY,
    output logic                  SDONE,
    output logic                  SERR,
    output logic                  STIMEOUT,
    output logic [DATA_WIDTH-1:0] SRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic [PROT_WIDTH-1:0] PPROT,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // A zero TIMEOUT still needs a one-bit counter so the declaration stays legal.
    localparam int            CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          timeout_hit;

    // Ready in IDLE, or in the completing ACCESS cycle so back-to-back
    // transfers go straight from ACCESS to SETUP without an idle gap.
    assign SREADY      = (state == IDLE) || ((state == ACCESS) && PREADY);
    assign accept      = transfer && SREADY;
    assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !PREADY && (wait_cnt == TMO);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSTRB    <= '0;
            PPROT    <= '0;
            SRDATA   <= '0;
            SDONE    <= 1'b0;
            SERR     <= 1'b0;
            STIMEOUT <= 1'b0;
        end else begin
            SDONE    <= 1'b0;
            SERR     <= 1'b0;
            STIMEOUT <= 1'b0;

            // Bus attributes only move on accept, so they stay frozen
            // from SETUP through the last ACCESS cycle.
            if (accept) begin
                PWRITE <= SWRITE;
                PADDR  <= SADDR;
                PPROT  <= SPROT;
                PSTRB  <= SWRITE ? SSTRB : '0;
                if (SWRITE) begin
                    PWDATA <= SWDATA;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SETUP;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        SDONE <= 1'b1;
                        SERR  <= PSLVERR;
                        if (!PWRITE) begin
                            SRDATA <= PRDATA;
                        end
                        if (accept) begin
                            // PSEL stays high; PENABLE drops for the new SETUP.
                            state    <= SETUP;
                            PENABLE  <= 1'b0;
                            wait_cnt <= '0;
                        end else begin
                            state   <= IDLE;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state    <= IDLE;
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        SDONE    <= 1'b1;
                        SERR     <= 1'b1;
                        STIMEOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed scenarios followed by randomized
// transfer groups, compared cycle by cycle against a transaction-level model.
// Inputs are driven 1 time unit after the rising edge, outputs checked 2 units after.
module tb_apb_master_bridge;

    localparam int TMO = 16;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        SWRITE = 1'b0;
    logic [31:0] SADDR = '0;
    logic [31:0] SWDATA = '0;
    logic [3:0]  SSTRB = '0;
    logic [2:0]  SPROT = '0;
    logic        SREADY;
    logic        SDONE;
    logic        SERR;
    logic        STIMEOUT;
    logic [31:0] SRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;

    apb_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .PROT_WIDTH(3), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .SWRITE(SWRITE),
        .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
        .SREADY(SREADY), .SDONE(SDONE), .SERR(SERR), .STIMEOUT(STIMEOUT),
        .SRDATA(SRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int tests = 0;
    int fails = 0;

    // Transaction-level model state: last written data and last read result.
    logic [31:0] m_wdata = '0;
    logic [31:0] m_srdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.wr   = 1'($urandom_range(0, 1));
        r.addr = $urandom & 32'hFFFF_FFFC;
        r.data = $urandom;
        r.strb = 4'($urandom_range(1, 15));
        r.prot = 3'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic drive_req(input req_t r);
        transfer = 1'b1;
        SWRITE   = r.wr;
        SADDR    = r.addr;
        SWDATA   = r.data;
        SSTRB    = r.strb;
        SPROT    = r.prot;
    endtask

    task automatic check_bus(input string tag, input req_t r, input logic en);
        check({tag, ".psel"},    64'(PSEL),    64'(1'b1));
        check({tag, ".penable"}, 64'(PENABLE), 64'(en));
        check({tag, ".pwrite"},  64'(PWRITE),  64'(r.wr));
        check({tag, ".paddr"},   64'(PADDR),   64'(r.addr));
        check({tag, ".pwdata"},  64'(PWDATA),  64'(m_wdata));
        check({tag, ".pstrb"},   64'(PSTRB),   64'(r.wr ? r.strb : 4'h0));
        check({tag, ".pprot"},   64'(PPROT),   64'(r.prot));
    endtask

    // Entered in the SETUP cycle of r; returns in the cycle where SDONE is high.
    // tmo: slave never answers; chain: nxt is offered in the completing ACCESS cycle.
    task automatic xfer(input string tag, input req_t r, input int waits, input bit tmo,
                        input bit err, input logic [31:0] rdata, input bit chain, input req_t nxt);
        int  n;
        bit  last;
        bit  rdy;
        transfer = 1'b0;
        if (r.wr) m_wdata = r.data;
        n = tmo ? TMO + 1 : waits + 1;
        #1;
        check_bus({tag, ".setup"}, r, 1'b0);
        check({tag, ".setup.sready"}, 64'(SREADY), 64'(1'b0));
        for (int i = 0; i < n; i++) begin
            tick();
            last    = (i == n - 1);
            rdy     = !tmo && last;
            PREADY  = rdy;
            PSLVERR = rdy ? err : 1'($urandom_range(0, 1));
            PRDATA  = (rdy && !r.wr) ? rdata : $urandom;
            if (last && chain) drive_req(nxt);
            if (last && tmo)   drive_req(rand_req());
            #1;
            check_bus({tag, ".access"}, r, 1'b1);
            check({tag, ".access.sdone"},  64'(SDONE),  64'(1'b0));
            check({tag, ".access.sready"}, 64'(SREADY), 64'(rdy));
        end
        tick();
        PREADY   = 1'b0;
        PSLVERR  = 1'($urandom_range(0, 1));
        PRDATA   = $urandom;
        transfer = 1'b0;
        #1;
        if (!r.wr && !tmo) m_srdata = rdata;
        check({tag, ".sdone"},    64'(SDONE),    64'(1'b1));
        check({tag, ".serr"},     64'(SERR),     64'(tmo | err));
        check({tag, ".stimeout"}, 64'(STIMEOUT), 64'(tmo));
        check({tag, ".srdata"},   64'(SRDATA),   64'(m_srdata));
        check({tag, ".done.psel"},    64'(PSEL),    64'(chain));
        check({tag, ".done.penable"}, 64'(PENABLE), 64'(1'b0));
        check({tag, ".done.sready"},  64'(SREADY),  64'(!chain));
    endtask

    task automatic idle_cycle(input string tag);
        tick();
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        #1;
        check({tag, ".idle.sdone"},    64'(SDONE),    64'(1'b0));
        check({tag, ".idle.serr"},     64'(SERR),     64'(1'b0));
        check({tag, ".idle.stimeout"}, 64'(STIMEOUT), 64'(1'b0));
        check({tag, ".idle.psel"},     64'(PSEL),     64'(1'b0));
        check({tag, ".idle.sready"},   64'(SREADY),   64'(1'b1));
    endtask

    task automatic single(input string tag, input req_t r, input int waits, input bit tmo,
                          input bit err, input logic [31:0] rdata);
        drive_req(r);
        #1;
        check({tag, ".accept.sready"}, 64'(SREADY), 64'(1'b1));
        tick();
        xfer(tag, r, waits, tmo, err, rdata, 1'b0, r);
        idle_cycle(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".psel"},     64'(PSEL),     64'(1'b0));
        check({tag, ".penable"},  64'(PENABLE),  64'(1'b0));
        check({tag, ".pwrite"},   64'(PWRITE),   64'(1'b0));
        check({tag, ".paddr"},    64'(PADDR),    64'(32'h0));
        check({tag, ".pwdata"},   64'(PWDATA),   64'(32'h0));
        check({tag, ".pstrb"},    64'(PSTRB),    64'(4'h0));
        check({tag, ".pprot"},    64'(PPROT),    64'(3'h0));
        check({tag, ".srdata"},   64'(SRDATA),   64'(32'h0));
        check({tag, ".sdone"},    64'(SDONE),    64'(1'b0));
        check({tag, ".serr"},     64'(SERR),     64'(1'b0));
        check({tag, ".stimeout"}, 64'(STIMEOUT), 64'(1'b0));
        check({tag, ".sready"},   64'(SREADY),   64'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t a;
        req_t b;
        req_t cur;
        req_t nxt;
        int   len;
        int   waits;
        bit   tmo;
        bit   chain;

        // Reset state
        PRESET = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        PRESET = 1'b0;

        // Zero-wait write
        a = '{wr: 1'b1, addr: 32'h10, data: 32'hDEAD_BEEF, strb: 4'hF, prot: 3'h2};
        single("wr0", a, 0, 1'b0, 1'b0, 32'h0);

        // Read with 3 wait states
        a = '{wr: 1'b0, addr: 32'h10, data: 32'h1234_5678, strb: 4'hA, prot: 3'h1};
        single("rd3", a, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back write 0x20 then read 0x24
        a = '{wr: 1'b1, addr: 32'h20, data: 32'hCAFE_F00D, strb: 4'h3, prot: 3'h0};
        b = '{wr: 1'b0, addr: 32'h24, data: 32'h0, strb: 4'hF, prot: 3'h5};
        drive_req(a);
        tick();
        xfer("b2b.wr", a, 0, 1'b0, 1'b0, 32'h0, 1'b1, b);
        xfer("b2b.rd", b, 1, 1'b0, 1'b0, 32'h0BAD_CAFE, 1'b0, b);
        idle_cycle("b2b");

        // Slave error on write: SRDATA must keep the previous read result
        a = '{wr: 1'b1, addr: 32'h30, data: 32'h5555_AAAA, strb: 4'hC, prot: 3'h3};
        single("slverr", a, 2, 1'b0, 1'b1, 32'h0);

        // Wait-state timeout on a read
        a = '{wr: 1'b0, addr: 32'h40, data: 32'h0, strb: 4'h0, prot: 3'h0};
        single("timeout", a, 0, 1'b1, 1'b0, 32'h0);

        // Exactly TIMEOUT wait states still completes normally
        a = '{wr: 1'b0, addr: 32'h44, data: 32'h0, strb: 4'h0, prot: 3'h4};
        single("maxwait", a, TMO, 1'b0, 1'b0, 32'h7777_1234);

        // Reset mid-ACCESS kills the transfer without SDONE
        a = '{wr: 1'b0, addr: 32'h50, data: 32'h0, strb: 4'h0, prot: 3'h0};
        drive_req(a);
        tick();
        transfer = 1'b0;
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        m_wdata  = '0;
        m_srdata = '0;
        check_all_zero("midreset");
        idle_cycle("midreset");
        single("postreset", a, 1, 1'b0, 1'b0, 32'h1357_9BDF);

        // Randomized groups of chained transfers
        for (int g = 0; g < 12; g++) begin
            len = $urandom_range(1, 3);
            cur = rand_req();
            drive_req(cur);
            tick();
            for (int j = 0; j < len; j++) begin
                chain = (j < len - 1);
                tmo   = !chain && ($urandom_range(0, 5) == 0);
                waits = $urandom_range(0, 4);
                nxt   = rand_req();
                xfer("rand", cur, waits, tmo, 1'($urandom_range(0, 1)), $urandom, chain, nxt);
                cur = nxt;
            end
            idle_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
